sram_1rw_arbiter: RTL and testbench

- Front-end controller for a small single-port (1RW) masked SRAM macro: 2 entries x 28 bits, write mask of 4 lanes x 7 bits, 1-cycle read latency.
- Runs a zero-fill of every entry after reset.
- Then arbitrates one write requester and one read requester onto the single port. Writes have priority; a starvation counter guarantees reads forward progress.
- Returns read data with a registered response-valid.

---
 rtl/sram_1rw_arbiter_if.sv | 32 +++
 rtl/sram_1rw_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_1rw_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1rw_arbiter_if.sv
// sram_1rw_arbiter_if: write/read requester handshake and read response bundle.
// Revision: 1.0
`default_nettype none

interface sram_1rw_arbiter_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 28,
  parameter int MASK_W = 4
);
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [MASK_W-1:0] w_mask;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output w_valid, w_addr, w_data, w_mask, r_valid, r_addr,
    input  w_ready, r_ready, resp_valid, resp_data
  );

  modport slave (
    input  w_valid, w_addr, w_data, w_mask, r_valid, r_addr,
    output w_ready, r_ready, resp_valid, resp_data
  );
endinterface

`default_nettype wire

// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: zero-fills a 1RW masked SRAM, then arbitrates write/read onto it.
// Optional SRAM_1RW_ARB_HOLD_RDATA_EN keeps resp_data at the last read value. Revision: 1.0
`default_nettype none

module sram_1rw_arbiter #(
  parameter int DEPTH        = 2,
  parameter int ADDR_W       = 1,
  parameter int DATA_W       = 28,
  parameter int MASK_W       = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  sram_1rw_arbiter_if.slave bus,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   init_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                resp_valid_q;
  logic                init_done_q;
  logic                force_rd;
  logic                w_fire;
  logic                r_fire;

  assign force_rd = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    state_next  = state;
    bus.w_ready = 1'b0;
    bus.r_ready = 1'b0;
    w_fire      = 1'b0;
    r_fire      = 1'b0;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = '0;
    sram_wmask  = '0;
    sram_wdata  = '0;
    case (state)
      S_INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt;
        sram_wmask = '1;
        if (init_cnt == ADDR_W'(DEPTH - 1)) state_next = S_RUN;
      end
      S_RUN: begin
        // Writes win unless the pending read has lost STARVE_LIMIT times in a row.
        bus.w_ready = !(bus.r_valid && force_rd);
        bus.r_ready = !(bus.w_valid && !force_rd);
        w_fire      = bus.w_valid && bus.w_ready;
        r_fire      = bus.r_valid && bus.r_ready;
        if (w_fire) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = bus.w_addr;
          sram_wmask = bus.w_mask;
          sram_wdata = bus.w_data;
        end else if (r_fire) begin
          sram_en    = 1'b1;
          sram_addr  = bus.r_addr;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_INIT;
      init_cnt     <= '0;
      starve_cnt   <= '0;
      resp_valid_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state        <= state_next;
      init_done_q  <= (state_next == S_RUN);
      resp_valid_q <= r_fire;
      if (state == S_INIT) begin
        init_cnt   <= init_cnt + 1'b1;
        starve_cnt <= '0;
      end else if (bus.r_valid && !r_fire) begin
        if (!force_rd) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign init_done      = init_done_q;
  assign bus.resp_valid = resp_valid_q;

`ifdef SRAM_1RW_ARB_HOLD_RDATA_EN
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q <= '0;
    end else if (resp_valid_q) begin
      hold_q <= sram_rdata;
    end
  end

  assign bus.resp_data = resp_valid_q ? sram_rdata : hold_q;
`else
  assign bus.resp_data = sram_rdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter: directed checks of zero-fill, arbitration, starvation and responses.
// Revision: 1.0
`default_nettype none

module tb_sram_1rw_arbiter;
  localparam int ADDR_W = 1;
  localparam int DATA_W = 28;
  localparam int MASK_W = 4;
  localparam int LANE_W = DATA_W / MASK_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_1rw_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  logic              init_done;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = 28'h3C3C3C3;

  sram_1rw_arbiter #(
    .DEPTH(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .STARVE_LIMIT(3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Macro model: masked write, registered-address read; non-zero contents expose a missing fill.
  logic [DATA_W-1:0] mem [2] = '{28'hABCDEF1, 28'h5A5A5A5};

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MASK_W; l++)
          if (sram_wmask[l]) mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.w_valid = 1'b0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
    bus.w_mask  = '0;
    bus.r_valid = 1'b0;
    bus.r_addr  = '0;
  endtask

  task automatic test_reset();
    logic [34:0] exp_bus;
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
`ifdef SRAM_1RW_ARB_HOLD_RDATA_EN
    checks++;
    if (bus.resp_data !== 28'h0) begin failures++; $display("FAIL hold_reset got=%h exp=0", bus.resp_data); end
`endif
    exp_bus = {1'b1, 1'b1, 1'b0, 4'hF, 28'h0};
    checks++;
    if ({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata} !== exp_bus) begin
      failures++; $display("FAIL init_fill0 got=%h exp=%h", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}, exp_bus);
    end
    checks++;
    if ({bus.w_ready, bus.r_ready, init_done, bus.resp_valid} !== 4'b0000) begin
      failures++; $display("FAIL init_ctl0 got=%b exp=0000", {bus.w_ready, bus.r_ready, init_done, bus.resp_valid});
    end
    cycle();
    exp_bus = {1'b1, 1'b1, 1'b1, 4'hF, 28'h0};
    checks++;
    if ({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata} !== exp_bus) begin
      failures++; $display("FAIL init_fill1 got=%h exp=%h", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}, exp_bus);
    end
    checks++;
    if ({bus.w_ready, bus.r_ready, init_done} !== 3'b000) begin
      failures++; $display("FAIL init_ctl1 got=%b exp=000", {bus.w_ready, bus.r_ready, init_done});
    end
    cycle();
    checks++;
    if ({init_done, sram_en} !== 2'b10) begin
      failures++; $display("FAIL init_done_c3 got=%b exp=10", {init_done, sram_en});
    end
    bus.r_valid = 1'b1;
    bus.r_addr  = 1'b0;
    #1;
    checks++;
    if ({bus.r_ready, sram_en, sram_wmode, sram_addr} !== 4'b1100) begin
      failures++; $display("FAIL zf_read_issue got=%b exp=1100", {bus.r_ready, sram_en, sram_wmode, sram_addr});
    end
    cycle();
    bus.r_addr = 1'b1;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 28'h0) begin
      failures++; $display("FAIL zf_read0 got=%b/%h exp=1/0000000", bus.resp_valid, bus.resp_data);
    end
    cycle();
    idle();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 28'h0) begin
      failures++; $display("FAIL zf_read1 got=%b/%h exp=1/0000000", bus.resp_valid, bus.resp_data);
    end
    cycle();
    checks++;
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL zf_idle resp_valid got=%b exp=0", bus.resp_valid); end
  endtask

  task automatic test_masked_write();
    bus.w_valid = 1'b1;
    bus.w_addr  = 1'b1;
    bus.w_data  = 28'hFFFFFFF;
    bus.w_mask  = 4'hF;
    #1;
    checks++;
    if ({bus.w_ready, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata} !== {3'b111, 1'b1, 4'hF, 28'hFFFFFFF}) begin
      failures++; $display("FAIL mw_full got=%h", {bus.w_ready, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata});
    end
    cycle();
    bus.w_data = 28'h0;
    bus.w_mask = 4'b0101;
    cycle();
    bus.w_addr = 1'b0;
    bus.w_data = 28'hFFFFFFF;
    bus.w_mask = 4'h0;
    #1;
    checks++;
    if ({bus.w_ready, sram_en, sram_wmode, sram_wmask} !== 7'b1110000) begin
      failures++; $display("FAIL mw_zero_mask got=%b exp=1110000", {bus.w_ready, sram_en, sram_wmode, sram_wmask});
    end
    cycle();
    idle();
    bus.r_valid = 1'b1;
    bus.r_addr  = 1'b1;
    cycle();
    bus.r_addr = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 28'hFE03F80) begin
      failures++; $display("FAIL mw_read got=%b/%h exp=1/fe03f80", bus.resp_valid, bus.resp_data);
    end
    cycle();
    idle();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 28'h0) begin
      failures++; $display("FAIL mw_zero_mask_read got=%b/%h exp=1/0000000", bus.resp_valid, bus.resp_data);
    end
    cycle();
  endtask

  task automatic test_starvation();
    logic rd_win;
    bus.w_valid = 1'b1;
    bus.w_addr  = 1'b0;
    bus.w_data  = 28'h0;
    bus.w_mask  = 4'hF;
    bus.r_valid = 1'b1;
    bus.r_addr  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      rd_win = (i % 4 == 3);
      checks++;
      if ({bus.w_ready, bus.r_ready, sram_wmode, sram_addr} !== {!rd_win, rd_win, !rd_win, rd_win}) begin
        failures++; $display("FAIL starve_arb i=%0d got=%b exp=%b", i, {bus.w_ready, bus.r_ready, sram_wmode, sram_addr}, {!rd_win, rd_win, !rd_win, rd_win});
      end
      checks++;
      if (bus.resp_valid !== (i % 4 == 0 && i > 0)) begin
        failures++; $display("FAIL starve_resp i=%0d got=%b exp=%b", i, bus.resp_valid, (i % 4 == 0 && i > 0));
      end
      cycle();
    end
    idle();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 28'hFE03F80) begin
      failures++; $display("FAIL starve_last_resp got=%b/%h exp=1/fe03f80", bus.resp_valid, bus.resp_data);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    bus.w_valid = 1'b1;
    bus.w_addr  = 1'b0;
    bus.w_data  = 28'h1234567;
    bus.w_mask  = 4'hF;
    cycle();
    bus.w_addr = 1'b1;
    bus.w_data = 28'h7654321;
    cycle();
    idle();
    bus.r_valid = 1'b1;
    bus.r_addr  = 1'b0;
    cycle();
    bus.r_addr = 1'b1;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 28'h1234567) begin
      failures++; $display("FAIL b2b_first got=%b/%h exp=1/1234567", bus.resp_valid, bus.resp_data);
    end
    cycle();
    idle();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 28'h7654321) begin
      failures++; $display("FAIL b2b_second got=%b/%h exp=1/7654321", bus.resp_valid, bus.resp_data);
    end
    cycle();
    checks++;
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_end resp_valid got=%b exp=0", bus.resp_valid); end
`ifdef SRAM_1RW_ARB_HOLD_RDATA_EN
    checks++;
    if (bus.resp_data !== 28'h7654321) begin failures++; $display("FAIL b2b_hold got=%h exp=7654321", bus.resp_data); end
`endif
  endtask

  task automatic test_reset_mid_init();
    idle();
    bus.r_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.r_ready !== 1'b1) begin failures++; $display("FAIL rst_read_accept got=%b exp=1", bus.r_ready); end
    cycle();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_no_resp got=%b exp=0", bus.resp_valid); end
    checks++;
    if ({sram_en, sram_addr, init_done} !== 3'b100) begin
      failures++; $display("FAIL rst_fill0 got=%b exp=100", {sram_en, sram_addr, init_done});
    end
    cycle();
    reset = 1'b1;
    checks++;
    if ({sram_en, sram_addr, init_done} !== 3'b110) begin
      failures++; $display("FAIL rst_fill1 got=%b exp=110", {sram_en, sram_addr, init_done});
    end
    cycle();
    reset = 1'b0;
    #1;
    checks++;
    if ({sram_en, sram_addr, init_done} !== 3'b100) begin
      failures++; $display("FAIL rst_restart0 got=%b exp=100", {sram_en, sram_addr, init_done});
    end
    cycle();
    checks++;
    if ({sram_en, sram_addr, init_done} !== 3'b110) begin
      failures++; $display("FAIL rst_restart1 got=%b exp=110", {sram_en, sram_addr, init_done});
    end
    cycle();
    checks++;
    if ({init_done, sram_en} !== 2'b10) begin
      failures++; $display("FAIL rst_done got=%b exp=10", {init_done, sram_en});
    end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_starvation();
    test_back_to_back();
    test_reset_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
